// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bundle: imem request/response, decode handshake, redirect
interface ifu_fetch_if #(
  parameter int XLEN = 64
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            mem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
           inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit, one fetch outstanding; optional IFU_ERR_TRAP_EN
module ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic         clk,
  input logic         rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0]     EBREAK  = 32'h0010_0073;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            started_q;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;

  logic            req_fire;
  logic [XLEN-1:0] redirect_tgt;

`ifdef IFU_ERR_TRAP_EN
  logic resp_err;
  assign resp_err = bus.mem_resp_err;
`else
  logic unused_resp_err;
  assign unused_resp_err = bus.mem_resp_err;
`endif

  // Requests are held off until the first edge after reset release.
  assign bus.mem_req_valid = started_q && (state_q == S_REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.fetch_fault   = fault_q;

  assign req_fire     = bus.mem_req_valid && bus.mem_req_ready;
  assign redirect_tgt = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // Next-state: normal REQ/WAIT/HOLD sequencing, then redirect overrides.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          drop_d  = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d   = S_HOLD;
            inst_d    = bus.mem_resp_data;
            inst_pc_d = pc_q;
            fault_d   = 1'b0;
`ifdef IFU_ERR_TRAP_EN
            if (resp_err) begin
              inst_d  = EBREAK;
              fault_d = 1'b1;
            end
`endif
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          fault_d = 1'b0;
`ifdef IFU_ERR_TRAP_EN
          if (fault_q) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
            pc_d    = pc_q + PC_STEP;
          end
`else
          state_d = S_REQ;
          pc_d    = pc_q + PC_STEP;
`endif
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_REQ;
    endcase

    if (bus.redirect_valid) begin
      pc_d    = redirect_tgt;
      fault_d = 1'b0;
      if (state_q == S_HOLD || state_q == S_FAULT) begin
        state_d = S_REQ;
      end
    end
  end

  // State, PC and the registered decode-side word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      started_q <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized scoreboard bench for ifu_fetch
module tb_ifu_fetch;
  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
    logic        fault;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if #(.XLEN(XLEN)) bus ();
  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int n_hs  = 0;

  // reference model state (owned by the stimulus process)
  item_t       exp_q[$];
  logic [63:0] model_pc;
  bit          parked, outstanding, out_stale, resp_given, resp_stale;
  bit          lat_pending, lat_exp, mon_en;
  logic [63:0] out_addr;
  int          delay;

  // monitor observations handed to the stimulus process
  bit          hs_seen, acc_seen;
  logic [63:0] acc_addr;
  bit          prev_iv, prev_hs, prev_red, prev_rv, prev_rr;
  logic [31:0] prev_inst;
  logic [63:0] prev_ipc, prev_addr;
  item_t       mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // instruction memory contents, a pure function of address
  function automatic logic [31:0] data_fn(input logic [63:0] a);
    logic [31:0] h;
    h = (a[31:0] - 32'h8000_0000) * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h0000_0513;
  endfunction

  function automatic logic err_fn(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h2545_F491;
    return h[31:29] == 3'b000;
  endfunction

  function automatic item_t item_for(input logic [63:0] pc);
    item_t it;
    it.pc    = pc;
    it.data  = data_fn(pc);
    it.fault = 1'b0;
`ifdef IFU_ERR_TRAP_EN
    if (err_fn(pc)) begin
      it.data  = 32'h0010_0073;
      it.fault = 1'b1;
    end
`endif
    return it;
  endfunction

  function automatic logic [63:0] pick_target(input bit wrap);
    if (wrap) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
    return 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 1023));
  endfunction

  // monitor: protocol checks and scoreboard pops at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hs_seen  = 0;
        acc_seen = 0;
        prev_iv  = 0;
        prev_rv  = 0;
      end else begin
        if (!bus.inst_valid) check("fault_idle", 64'(bus.fetch_fault), 64'd0);
        if (outstanding || resp_given || parked) check("req_blocked", 64'(bus.mem_req_valid), 64'd0);
        if (prev_rv && !prev_rr && !prev_red) begin
          check("req_hold_valid", 64'(bus.mem_req_valid), 64'd1);
          check("req_hold_addr", bus.mem_req_addr, prev_addr);
        end
        if (prev_iv && !prev_hs && !prev_red) begin
          check("hold_valid", 64'(bus.inst_valid), 64'd1);
          check("hold_inst", 64'(bus.inst), 64'(prev_inst));
          check("hold_pc", bus.inst_pc, prev_ipc);
        end
        if (lat_pending) check("resp_latency", 64'(bus.inst_valid), 64'(lat_exp));
        acc_seen = bus.mem_req_valid && bus.mem_req_ready;
        acc_addr = bus.mem_req_addr;
        if (acc_seen) check("req_addr", bus.mem_req_addr, model_pc);
        hs_seen = bus.inst_valid && bus.inst_ready;
        if (hs_seen) begin
          n_hs++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_inst: got pc %h, expected no instruction", bus.inst_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("inst", 64'(bus.inst), 64'(mon_e.data));
            check("inst_pc", bus.inst_pc, mon_e.pc);
            check("fetch_fault", 64'(bus.fetch_fault), 64'(mon_e.fault));
          end
        end
        prev_iv   = bus.inst_valid;
        prev_hs   = hs_seen;
        prev_red  = bus.redirect_valid;
        prev_rv   = bus.mem_req_valid;
        prev_rr   = bus.mem_req_ready;
        prev_inst = bus.inst;
        prev_ipc  = bus.inst_pc;
        prev_addr = bus.mem_req_addr;
      end
    end
  end

  task automatic do_reset();
    mon_en = 0;
    rst_n  = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    @(negedge clk);
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst", 64'(bus.inst), 64'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);
    check("rst_fault", 64'(bus.fetch_fault), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid_held", 64'(bus.mem_req_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // a stray beat while in REQ must be ignored
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    bus.mem_resp_err   = 1'b1;
    @(negedge clk);
    check("first_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("first_req_addr", bus.mem_req_addr, RESET_PC);
    check("stray_beat_ignored", 64'(bus.inst_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    exp_q.delete();
    model_pc    = RESET_PC;
    exp_q.push_back(item_for(RESET_PC));
    parked      = 0;
    outstanding = 0;
    out_stale   = 0;
    resp_given  = 0;
    resp_stale  = 0;
    lat_pending = 0;
    lat_exp     = 0;
    mon_en      = 1;
  endtask

  // one cycle: fold last cycle's events into the model, then drive this cycle
  task automatic step_cycle(input int p_mready, input int p_iready, input int p_red, input bit wrap);
    bit          red;
    logic [63:0] tgt;
    item_t       cur;
    red = bus.redirect_valid;
    tgt = {bus.redirect_pc[63:2], 2'b00};
    lat_pending = resp_given;
    lat_exp     = resp_given && !resp_stale && !red;
    resp_given  = 0;
    if (acc_seen) begin
      outstanding = 1;
      out_addr    = acc_addr;
      out_stale   = 0;
      delay       = $urandom_range(0, 2);
    end
    if (red) begin
      if (outstanding) out_stale = 1;
      exp_q.delete();
      model_pc = tgt;
      parked   = 0;
      exp_q.push_back(item_for(tgt));
    end else if (hs_seen) begin
      cur = item_for(model_pc);
      if (cur.fault) begin
        parked = 1;
      end else begin
        model_pc = model_pc + 64'd4;
        exp_q.push_back(item_for(model_pc));
      end
    end

    if (outstanding && delay == 0) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = data_fn(out_addr);
      bus.mem_resp_err   = err_fn(out_addr);
      outstanding = 0;
      resp_given  = 1;
      resp_stale  = out_stale;
    end else begin
      if (outstanding) delay--;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
      bus.mem_resp_err   = 1'($urandom_range(0, 1));
    end
    bus.mem_req_ready  = ($urandom_range(0, 99) < p_mready);
    bus.inst_ready     = ($urandom_range(0, 99) < p_iready);
    bus.redirect_valid = ($urandom_range(0, 99) < p_red);
    bus.redirect_pc    = pick_target(wrap);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles, input int p_mready, input int p_iready, input int p_red, input bit wrap);
    for (int i = 0; i < cycles; i++) step_cycle(p_mready, p_iready, p_red, wrap);
  endtask

  initial begin
    do_reset();
    run(40, 100, 100, 0, 0);
    run(400, 60, 40, 8, 0);
    run(300, 70, 60, 10, 1);
    run(200, 30, 20, 5, 0);
    do_reset();
    run(400, 50, 50, 7, 0);
    check("progress", 64'(n_hs > 100), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Produces the 32-bit instruction stream that the control-unit decoder consumes.
- Owns the PC. Issues single-beat reads to instruction memory and registers each returned word.
- Presents each word plus its PC to decode over a valid/ready handshake.
- Accepts redirects (jal/jalr/taken branch) from execute, one fetch outstanding at a time.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  fetch address (word aligned)
mem_resp_valid  in  1  response beat, one per accepted request, no backpressure
mem_resp_data  in  32  instruction word
mem_resp_err  in  1  access fault for this beat
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  32  instruction word to decoder
inst_pc  out  XLEN  PC of inst
redirect_valid  in  1  control-flow redirect, single-cycle pulse
redirect_pc  in  XLEN  redirect target
fetch_fault  out  1  qualifies inst: fetch error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=REQ, pc=RESET_PC, drop=0.
  - mem_req_valid=0 while rst_n=0, 1 from the first edge after release.
  - inst_valid=0, inst=0, inst_pc=0, fetch_fault=0.
- Reset asserted mid-transaction: all state clears. A late mem_resp_valid after reset is ignored unless state=WAIT.
- State REQ:
  - mem_req_valid=1, mem_req_addr=pc.
  - mem_req_valid&mem_req_ready -> WAIT.
  - mem_req_addr changes while unaccepted only on redirect.
- State WAIT:
  - mem_req_valid=0. On mem_resp_valid, latch inst<=mem_resp_data and inst_pc<=pc.
  - If drop=0 -> HOLD. If drop=1 -> discard the beat, clear drop, go REQ.
- State HOLD:
  - inst_valid=1. inst and inst_pc stay stable until handshake.
  - inst_valid&inst_ready -> pc<=pc+4, go REQ.
  - inst_valid drops the cycle after the handshake.
- Latency: response beat at cycle M gives inst_valid at M+1. Best-case issue interval is 3 cycles (REQ/WAIT/HOLD).
- Redirect (priority over normal sequencing; pc<=redirect_pc in every case):
  - REQ, no request handshake: stay REQ; next cycle mem_req_addr=redirect_pc.
  - REQ, same-cycle request handshake: go WAIT with drop=1.
  - WAIT, no response: set drop=1.
  - WAIT, same-cycle response: discard the beat, go REQ.
  - HOLD: instruction killed, inst_valid=0 next cycle, go REQ. If inst_ready was also high, the handshake still counts (the word was consumed) but pc takes redirect_pc, not pc+4.
- Misaligned redirect_pc[1:0]!=0: bits [1:0] forced to 0 on load; no fault.
- PC arithmetic: pc+4 modulo 2^XLEN, wraps silently.

Optional Feature:
- Macro: IFU_ERR_TRAP_EN.
- Defined:
  - mem_resp_err=1 in WAIT with drop=0 -> HOLD with inst=32'h0010_0073 (ebreak) and fetch_fault=1.
  - fetch_fault clears on handshake or redirect.
  - After that handshake the PC does not advance; the unit parks in a FAULT state with mem_req_valid=0 until a redirect.
- Not defined: mem_resp_err ignored, data passed unchanged, fetch_fault tied 0.

Test Plan:
- Reset release, mem_req_ready=1, response data 32'h0000_0513 one cycle later, inst_ready=1 -> first mem_req_addr=0x80000000; inst=0x00000513, inst_pc=0x80000000; next request addr 0x80000004.
- inst_ready held 0 for 5 cycles in HOLD -> inst, inst_pc stable, no new mem_req_valid; release -> next addr pc+4.
- redirect_valid with redirect_pc=0x80000100 while in WAIT, response arrives 2 cycles later -> beat discarded, inst_valid stays 0, next mem_req_addr=0x80000100.
- redirect in HOLD with inst_ready=1, redirect_pc=0x80000203 -> handshake counted, next mem_req_addr=0x80000200.
- mem_req_ready low 4 cycles -> mem_req_valid held, addr stable; pc=0xFFFF_FFFF_FFFF_FFFC fetch accepted -> following addr 0x0.
- IFU_ERR_TRAP_EN defined, mem_resp_err=1 -> inst=0x00100073, fetch_fault=1; after handshake no request until redirect to 0x80000000. Macro undefined -> raw data, fetch_fault=0.
